// File: rtl/intr_ctrl_if.sv
// Bus between the CPU datapath and the interrupt controller.
// master: CPU side (drives requests/config, sees take/vector);
// slave: controller side.
interface intr_ctrl_if #(
    parameter int N_IRQ = 4,
    parameter int PC_W  = 10,
    parameter int TMR_W = 7,
    parameter int ID_W  = $clog2(N_IRQ)
);
    logic [N_IRQ-1:0] irq;
    logic             gie;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_d;
    logic             vec_we;
    logic [ID_W-1:0]  vec_sel;
    logic [PC_W-1:0]  vec_d;
    logic             tmr_we;
    logic [TMR_W-1:0] tmr_d;
    logic             tmr_en;
    logic             ret;
    logic             take;
    logic [PC_W-1:0]  vector;
    logic [ID_W-1:0]  active_id;
    logic [N_IRQ-1:0] in_service;
    logic             spurious_ret;

    modport master (
        output irq, gie, mask_we, mask_d,
        output vec_we, vec_sel, vec_d,
        output tmr_we, tmr_d, tmr_en, ret,
        input  take, vector, active_id,
        input  in_service, spurious_ret
    );

    modport slave (
        input  irq, gie, mask_we, mask_d,
        input  vec_we, vec_sel, vec_d,
        input  tmr_we, tmr_d, tmr_en, ret,
        output take, vector, active_id,
        output in_service, spurious_ret
    );
endinterface

// File: rtl/intr_ctrl.sv
// Vectored, nested, priority interrupt controller with auto-reload timer.
// Ports: clk, reset (async active-low), bus (intr_ctrl_if.slave):
//   irq/gie/mask/vec/tmr/ret in; take/vector/active_id/in_service/
//   spurious_ret out. Channel 0 is the highest priority.
module intr_ctrl #(
    parameter int              N_IRQ      = 4,
    parameter int              PC_W       = 10,
    parameter int              TMR_W      = 7,
    parameter int              TMR_CH     = N_IRQ - 1,
    parameter logic [PC_W-1:0] VEC_BASE   = 10'h3C0,
    parameter int              VEC_STRIDE = 16
) (
    input  logic      clk,
    input  logic      reset,
    intr_ctrl_if.slave bus
);
    localparam int ID_W = $clog2(N_IRQ);

    logic [N_IRQ-1:0] r_irq_q;
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] r_mask;
    logic [N_IRQ-1:0] r_insvc;
    logic             r_spur;
    logic [TMR_W-1:0] r_cnt;
    logic [TMR_W-1:0] r_thr;
    logic [PC_W-1:0]  r_vec [N_IRQ];

    logic             w_tick;
    logic [N_IRQ-1:0] w_edge;
    logic [N_IRQ-1:0] w_elig;
    logic [ID_W-1:0]  w_cand;
    logic             w_cand_ok;
    logic [ID_W-1:0]  w_isv_id;
    logic             w_isv_any;
    logic             w_take;
    logic [N_IRQ-1:0] w_take_oh;
    logic [N_IRQ-1:0] w_ret_oh;

    assign w_tick = bus.tmr_en & (r_thr != '0) & (r_cnt == r_thr);
    assign w_elig = r_pend & r_mask;

    always_comb begin
        w_edge = bus.irq & ~r_irq_q;
        w_edge[TMR_CH] = w_edge[TMR_CH] | w_tick;
    end

    // Downward scan so the lowest set index is the one that sticks.
    always_comb begin
        w_cand    = '0;
        w_cand_ok = 1'b0;
        w_isv_id  = '0;
        w_isv_any = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_cand    = ID_W'(i);
                w_cand_ok = 1'b1;
            end
            if (r_insvc[i]) begin
                w_isv_id  = ID_W'(i);
                w_isv_any = 1'b1;
            end
        end
    end

    // Only a strictly higher priority channel may preempt.
    assign w_take = bus.gie & ~bus.ret & w_cand_ok &
                    (~w_isv_any | (w_cand < w_isv_id));

    assign w_take_oh = N_IRQ'(w_take) << w_cand;
    assign w_ret_oh  = N_IRQ'(bus.ret & w_isv_any) << w_isv_id;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_q <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_insvc <= '0;
            r_spur  <= 1'b0;
            r_cnt   <= '0;
            r_thr   <= '0;
            for (int i = 0; i < N_IRQ; i++) begin
                r_vec[i] <= PC_W'(int'(VEC_BASE) + i * VEC_STRIDE);
            end
        end else begin
            r_irq_q <= bus.irq;
            // New edge beats the clear of a channel taken this cycle.
            r_pend  <= (r_pend & ~w_take_oh) | w_edge;
            r_insvc <= (r_insvc | w_take_oh) & ~w_ret_oh;
            if (bus.ret && !w_isv_any) begin
                r_spur <= 1'b1;
            end
            if (bus.mask_we) begin
                r_mask <= bus.mask_d;
            end
            if (bus.vec_we && (int'(bus.vec_sel) < N_IRQ)) begin
                r_vec[bus.vec_sel] <= bus.vec_d;
            end
            if (bus.tmr_we) begin
                r_thr <= bus.tmr_d;
                r_cnt <= '0;
            end else if (bus.tmr_en) begin
                if (w_tick || r_thr == '0) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + TMR_W'(1);
                end
            end
        end
    end

    assign bus.take         = w_take;
    assign bus.vector       = w_take ? r_vec[w_cand] : '0;
    assign bus.active_id    = w_isv_id;
    assign bus.in_service   = r_insvc;
    assign bus.spurious_ret = r_spur;
endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed steps then random traffic,
// all cycles checked against a behavioural model.
module tb_intr_ctrl;
    localparam int N   = 4;
    localparam int PW  = 10;
    localparam int TW  = 7;
    localparam int TCH = 3;

    logic clk = 1'b0;
    logic reset;

    intr_ctrl_if #(.N_IRQ(N), .PC_W(PW), .TMR_W(TW)) bus();

    intr_ctrl #(
        .N_IRQ(N), .PC_W(PW), .TMR_W(TW), .TMR_CH(TCH),
        .VEC_BASE(10'h3C0), .VEC_STRIDE(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int takes;

    logic [N-1:0]  m_irqq, m_pend, m_mask, m_isv;
    logic          m_spur;
    int            m_cnt, m_thr;
    logic [PW-1:0] m_vec [N];

    function automatic int first(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_irqq = '0; m_pend = '0; m_mask = '0; m_isv = '0;
        m_spur = 1'b0; m_cnt = 0; m_thr = 0;
        for (int i = 0; i < N; i++) m_vec[i] = PW'(10'h3C0 + i * 16);
    endtask

    function automatic bit m_take(output int c, output int s);
        c = first(m_pend & m_mask);
        s = first(m_isv);
        return bus.gie && !bus.ret && c >= 0 && (s < 0 || c < s);
    endfunction

    task automatic check_model();
        int c, s;
        bit t;
        t = m_take(c, s);
        chk("take", 32'(bus.take), 32'(t));
        chk("vector", 32'(bus.vector), t ? 32'(m_vec[c]) : 0);
        chk("active_id", 32'(bus.active_id), s < 0 ? 0 : s);
        chk("in_service", 32'(bus.in_service), 32'(m_isv));
        chk("spurious", 32'(bus.spurious_ret), 32'(m_spur));
    endtask

    task automatic commit();
        int c, s;
        bit t, tick;
        logic [N-1:0] e;
        t = m_take(c, s);
        tick = bus.tmr_en && m_thr != 0 && m_cnt == m_thr;
        e = bus.irq & ~m_irqq;
        if (tick) e[TCH] = 1'b1;
        if (t) begin
            m_pend[c] = 1'b0;
            m_isv[c]  = 1'b1;
        end
        m_pend = m_pend | e;
        if (bus.ret) begin
            if (s >= 0) m_isv[s] = 1'b0;
            else m_spur = 1'b1;
        end
        m_irqq = bus.irq;
        if (bus.mask_we) m_mask = bus.mask_d;
        if (bus.vec_we && int'(bus.vec_sel) < N) m_vec[bus.vec_sel] = bus.vec_d;
        if (bus.tmr_we) begin
            m_cnt = 0;
            m_thr = int'(bus.tmr_d);
        end else if (bus.tmr_en) begin
            if (m_thr == 0 || tick) m_cnt = 0;
            else m_cnt = m_cnt + 1;
        end
    endtask

    task automatic cyc();
        #1;
        check_model();
        commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_take", 32'(bus.take), 0);
        chk("rst_isv", 32'(bus.in_service), 0);
        chk("rst_vector", 32'(bus.vector), 0);
        chk("rst_spur", 32'(bus.spurious_ret), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        bus.irq = '1; bus.gie = 1'b1; bus.ret = 1'b0;
        bus.mask_we = 1'b0; bus.mask_d = '0;
        bus.vec_we = 1'b0; bus.vec_sel = '0; bus.vec_d = '0;
        bus.tmr_we = 1'b0; bus.tmr_d = '0; bus.tmr_en = 1'b0;
        #2;
        do_reset();
        #1;
        chk("noedge_take", 32'(bus.take), 0);
        cyc(); cyc(); cyc();
        bus.irq = '0;
        do_reset();

        // basic vector
        bus.mask_we = 1'b1; bus.mask_d = 4'b1111; cyc();
        bus.mask_we = 1'b0;
        bus.irq = 4'b0100; cyc();
        bus.irq = 4'b0000;
        #1;
        chk("basic_take", 32'(bus.take), 1);
        chk("basic_vec", 32'(bus.vector), 32'h3E0);
        cyc();
        #1;
        chk("basic_once", 32'(bus.take), 0);
        chk("basic_isv", 32'(bus.in_service), 32'b0100);
        cyc();
        bus.ret = 1'b1; cyc();
        bus.ret = 1'b0;
        #1;
        chk("basic_ret", 32'(bus.in_service), 0);
        cyc();

        // priority and nesting
        bus.irq = 4'b0100; cyc();
        bus.irq = 4'b0000; cyc();
        bus.irq = 4'b1000; cyc();
        bus.irq = 4'b0000;
        #1;
        chk("lowprio_hold", 32'(bus.take), 0);
        cyc();
        bus.irq = 4'b0010; cyc();
        bus.irq = 4'b0000;
        #1;
        chk("nest_take", 32'(bus.take), 1);
        chk("nest_vec", 32'(bus.vector), 32'h3D0);
        cyc();
        #1;
        chk("nest_isv", 32'(bus.in_service), 32'b0110);
        chk("nest_active", 32'(bus.active_id), 1);
        bus.ret = 1'b1; cyc();
        bus.ret = 1'b0;
        #1;
        chk("nest_ret1", 32'(bus.in_service), 32'b0100);
        bus.ret = 1'b1; cyc();
        bus.ret = 1'b0;
        #1;
        chk("nest_ret2", 32'(bus.in_service), 0);
        chk("ch3_take", 32'(bus.take), 1);
        chk("ch3_vec", 32'(bus.vector), 32'h3F0);
        cyc();
        bus.ret = 1'b1; cyc();
        bus.ret = 1'b0;

        // mask and vector write
        bus.mask_we = 1'b1; bus.mask_d = 4'b0000; cyc();
        bus.mask_we = 1'b0;
        bus.irq = 4'b0001; cyc();
        bus.irq = 4'b0000;
        #1;
        chk("masked_take", 32'(bus.take), 0);
        cyc();
        bus.vec_we = 1'b1; bus.vec_sel = 2'd0; bus.vec_d = 10'h100; cyc();
        bus.vec_we = 1'b0;
        bus.mask_we = 1'b1; bus.mask_d = 4'b0001; cyc();
        bus.mask_we = 1'b0;
        #1;
        chk("unmask_take", 32'(bus.take), 1);
        chk("unmask_vec", 32'(bus.vector), 32'h100);
        cyc();
        bus.ret = 1'b1; cyc();
        bus.ret = 1'b0;

        // timer: threshold 3 -> tick every 4 cycles
        bus.mask_we = 1'b1; bus.mask_d = 4'b1000;
        bus.tmr_we = 1'b1; bus.tmr_d = 7'd3; bus.tmr_en = 1'b1;
        cyc();
        bus.mask_we = 1'b0; bus.tmr_we = 1'b0;
        takes = 0;
        for (int k = 0; k < 16; k++) begin
            bus.ret = m_isv[3];
            #1;
            if (bus.take && bus.vector == 10'h3F0) takes++;
            cyc();
        end
        chk("tmr_takes", 32'(takes), 3);
        bus.ret = 1'b0;
        bus.tmr_we = 1'b1; bus.tmr_d = 7'd0; cyc();
        bus.tmr_we = 1'b0;
        takes = 0;
        for (int k = 0; k < 12; k++) begin
            bus.ret = m_isv[3];
            #1;
            if (bus.take) takes++;
            cyc();
        end
        chk("tmr_off_takes", 32'(takes), 0);
        bus.ret = 1'b0; bus.tmr_en = 1'b0;

        // spurious return is sticky
        bus.ret = 1'b1; cyc();
        bus.ret = 1'b0;
        #1;
        chk("spur_set", 32'(bus.spurious_ret), 1);
        cyc(); cyc(); cyc();
        #1;
        chk("spur_sticky", 32'(bus.spurious_ret), 1);

        // ret blocks take for one cycle
        bus.mask_we = 1'b1; bus.mask_d = 4'b1111; cyc();
        bus.mask_we = 1'b0;
        bus.irq = 4'b0001; cyc();
        bus.irq = 4'b0000; bus.ret = 1'b1;
        #1;
        chk("ret_block", 32'(bus.take), 0);
        cyc();
        bus.ret = 1'b0;
        #1;
        chk("ret_after", 32'(bus.take), 1);
        cyc();
        bus.ret = 1'b1; cyc();
        bus.ret = 1'b0;

        // edge in the same cycle the channel is taken
        bus.gie = 1'b0; bus.irq = 4'b0010; cyc();
        bus.irq = 4'b0000; cyc();
        bus.gie = 1'b1; bus.irq = 4'b0010;
        #1;
        chk("same_take", 32'(bus.take), 1);
        cyc();
        bus.irq = 4'b0000;
        #1;
        chk("same_noretake", 32'(bus.take), 0);
        chk("same_isv", 32'(bus.in_service), 32'b0010);
        cyc();
        bus.ret = 1'b1; cyc();
        bus.ret = 1'b0;
        #1;
        chk("same_repend", 32'(bus.take), 1);
        chk("same_vec", 32'(bus.vector), 32'h3D0);
        cyc();

        // reset mid-service
        bus.irq = 4'b0100; cyc();
        bus.irq = 4'b0000;
        do_reset();
        cyc();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            bus.irq     = N'($urandom);
            bus.gie     = ($urandom % 8) != 0;
            bus.ret     = ($urandom % 5) == 0;
            bus.mask_we = ($urandom % 10) == 0;
            bus.mask_d  = N'($urandom);
            bus.vec_we  = ($urandom % 12) == 0;
            bus.vec_sel = 2'($urandom);
            bus.vec_d   = PW'($urandom);
            bus.tmr_we  = ($urandom % 25) == 0;
            bus.tmr_d   = TW'($urandom % 6);
            bus.tmr_en  = ($urandom % 4) != 0;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
